// File: rtl/aes_pkg.sv
// Shared widths, FSM state encoding and word byte-swap helper for the AXI-Stream block packer.
package aes_pkg;

  localparam int unsigned WORD_S        = 32;
  localparam int unsigned BLK_S         = 128;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned CNT_W         = 2;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reverse byte order of one stream word.
  function automatic logic [WORD_S-1:0] byte_swap(input logic [WORD_S-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/blk_word_packer.sv
// Packs stream words MSW-first into a 128-bit block with zero-fill on early end.
// Build option: AXIS_BYTE_SWAP_EN byte-reverses each data word before packing.
module blk_word_packer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              word_en,
  input  logic [WORD_S-1:0] word,
  input  logic              last,
  input  logic              clr,
  output logic [BLK_S-1:0]  blk_c,
  output logic              last_slot_c
);

  logic [WORD_S-1:0]       word_in;
  logic [BLK_S-WORD_S-1:0] sr;
  logic [CNT_W-1:0]        count;

`ifdef AXIS_BYTE_SWAP_EN
  assign word_in = byte_swap(word);
`else
  assign word_in = word;
`endif

  assign last_slot_c = (count == CNT_W'(WORDS_PER_BLK - 1));

  // Earlier words sit in the shift register; the current word closes the block.
  always_comb begin
    blk_c = '0;
    case (count)
      2'd0:    blk_c = {word_in, (BLK_S-WORD_S)'(0)};
      2'd1:    blk_c = {sr[WORD_S-1:0], word_in, (BLK_S-2*WORD_S)'(0)};
      2'd2:    blk_c = {sr[2*WORD_S-1:0], word_in, WORD_S'(0)};
      default: blk_c = {sr, word_in};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      count <= '0;
    end else if (clr) begin
      sr    <= '0;
      count <= '0;
    end else if (word_en) begin
      if (last || last_slot_c) begin
        sr    <= '0;
        count <= '0;
      end else begin
        sr    <= {sr[BLK_S-2*WORD_S-1:0], word_in};
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/axis_blk_packer.sv
// Accepts a command word plus data words from a DMA stream and emits 128-bit blocks to a FIFO.
// Build option: AXIS_BYTE_SWAP_EN (handled in blk_word_packer) byte-reverses data words.
module axis_blk_packer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_S-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [WORD_S-1:0] aes_cmd,
  output logic [BLK_S-1:0]  in_fifo_write_tdata,
  output logic              in_fifo_write_tvalid,
  input  logic              in_fifo_write_tready,
  output logic              axis_slave_done,
  input  logic              processing_done,
  output logic              pkt_err
);

  state_t             state;
  logic               word_en;
  logic               clr;
  logic               blk_end;
  logic               last_slot_c;
  logic [BLK_S-1:0]   blk_c;

  assign word_en = (state == PACK) && s_axis_tvalid && s_axis_tready;
  assign clr     = (state == DONE) && axis_slave_done && processing_done;
  assign blk_end = last_slot_c || s_axis_tlast;

  blk_word_packer u_packer (
    .clk         (clk),
    .rst_n       (reset),
    .word_en     (word_en),
    .word        (s_axis_tdata),
    .last        (s_axis_tlast),
    .clr         (clr),
    .blk_c       (blk_c),
    .last_slot_c (last_slot_c)
  );

  // Packet FSM; tready is registered, so each branch sets the value for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= CMD;
      s_axis_tready        <= 1'b0;
      aes_cmd              <= '0;
      in_fifo_write_tdata  <= '0;
      in_fifo_write_tvalid <= 1'b0;
      axis_slave_done      <= 1'b0;
      pkt_err              <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          s_axis_tready <= 1'b1;
          if (s_axis_tvalid && s_axis_tready) begin
            aes_cmd <= s_axis_tdata;
            if (s_axis_tlast) begin
              pkt_err       <= 1'b1;
              s_axis_tready <= 1'b0;
              state         <= DONE;
            end else begin
              state <= PACK;
            end
          end
        end

        PACK: begin
          if (word_en) begin
            if (blk_end) begin
              in_fifo_write_tdata  <= blk_c;
              in_fifo_write_tvalid <= 1'b1;
              s_axis_tready        <= 1'b0;
              if (s_axis_tlast) begin
                state <= DONE;
                if (!last_slot_c) pkt_err <= 1'b1;
              end
            end
          end else if (in_fifo_write_tvalid && in_fifo_write_tready) begin
            in_fifo_write_tvalid <= 1'b0;
            s_axis_tready        <= 1'b1;
          end else begin
            s_axis_tready <= !in_fifo_write_tvalid;
          end
        end

        DONE: begin
          s_axis_tready <= 1'b0;
          if (in_fifo_write_tvalid && in_fifo_write_tready) in_fifo_write_tvalid <= 1'b0;
          if (axis_slave_done) begin
            if (processing_done) begin
              axis_slave_done <= 1'b0;
              pkt_err         <= 1'b0;
              s_axis_tready   <= 1'b1;
              state           <= CMD;
            end
          end else if (!in_fifo_write_tvalid || in_fifo_write_tready) begin
            axis_slave_done <= 1'b1;
          end
        end

        default: begin
          s_axis_tready <= 1'b0;
          state         <= CMD;
        end
      endcase
    end
  end

endmodule

// File: doc/axis_blk_packer.md
AXIS_BLK_PACKER -- requirements
Module: axis_blk_packer

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  DMA word.
- s_axis_tvalid  in  1  DMA word valid.
- s_axis_tlast  in  1  last word of packet.
- s_axis_tready  out  1  word accepted when tvalid && tready.
- aes_cmd  out  32  command word of the current packet.
- in_fifo_write_tdata  out  128  packed block to the input FIFO.
- in_fifo_write_tvalid  out  1  block valid.
- in_fifo_write_tready  in  1  FIFO can accept a block.
- axis_slave_done  out  1  level; all blocks of the packet delivered.
- processing_done  in  1  controller finished the packet; re-arm.
- pkt_err  out  1  sticky; malformed packet length.

REQ-002 SHALL have no parameters; widths SHALL come from the shared package.

Function
REQ-003 SHALL use FSM states CMD, PACK, DONE.
REQ-004 In CMD: s_axis_tready=1; the first accepted word SHALL be latched into aes_cmd; next state PACK.
  - If that word has tlast=1: set pkt_err; next state DONE.
REQ-005 In PACK, words SHALL fill the block MSW first:
  - word 0 goes to [127:96], word 3 goes to [31:0].
  - A 2-bit counter SHALL wrap 3->0.
REQ-006 On the 4th word: register the block and assert in_fifo_write_tvalid on the next cycle (latency 1 cycle from the last word).
REQ-007 s_axis_tready in PACK SHALL be !in_fifo_write_tvalid; no new word is accepted while a block is pending.
REQ-008 in_fifo_write_tvalid SHALL stay high, with tdata stable, until in_fifo_write_tready is sampled high; it then clears.
REQ-009 tlast on the 4th word SHALL emit the block and then go to DONE.
REQ-010 tlast on word 0-2 SHALL zero-fill the remaining words, emit the block, set pkt_err, and go to DONE.
REQ-011 In DONE: s_axis_tready=0.
  - axis_slave_done SHALL go high once no block is pending.
  - axis_slave_done SHALL stay high until processing_done is sampled high.
  - Then: axis_slave_done=0, pkt_err=0, counter=0, next state CMD.
REQ-012 processing_done outside DONE SHALL be ignored.
REQ-013 aes_cmd SHALL hold until the next packet's command word is accepted.

Reset
REQ-014 While reset=0, asynchronously, SHALL force:
  - state=CMD and counter=0.
  - s_axis_tready=0 (rises the first cycle after release).
  - in_fifo_write_tvalid=0, axis_slave_done=0, pkt_err=0.
  - aes_cmd=0 and in_fifo_write_tdata=0.
REQ-015 Reset mid-packet SHALL discard the partial block; no block is emitted after release until a new command word arrives.

Configuration
REQ-016 With AXIS_BYTE_SWAP_EN defined, each data word SHALL be byte-reversed ([7:0]<->[31:24], [15:8]<->[23:16]) before packing; aes_cmd is never swapped.
REQ-017 Without AXIS_BYTE_SWAP_EN, words SHALL pack unmodified.

Structure
REQ-018 The shared package aes_pkg SHALL hold WORD_S=32, BLK_S=128, WORDS_PER_BLK=4 and the FSM state enum.
REQ-019 Shift register, counter and byte swap SHALL live in one sub-module, blk_word_packer; the FSM and handshakes stay in the top level.

Verification
REQ-020 The bench SHALL cover:
- Packet 0x00000011, 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF(tlast): aes_cmd=0x00000011; one block 0x00112233445566778899AABBCCDDEEFF; axis_slave_done=1; pkt_err=0.
- Same packet with in_fifo_write_tready held 0 for 10 cycles: tvalid and tdata stable; s_axis_tready=0 throughout; block delivered once.
- Packet cmd, 0xAAAAAAAA, 0xBBBBBBBB(tlast): block 0xAAAAAAAABBBBBBBB0000000000000000; pkt_err=1.
- AXIS_BYTE_SWAP_EN defined, data word 0x01020304: packed word 0x04030201; aes_cmd unswapped.
- processing_done pulse in DONE: done/pkt_err clear next cycle; next packet's first word lands in aes_cmd. Reset asserted after 2 data words: no block emitted; all outputs 0.
